// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Phase lengths of zero are promoted to one cycle by eff_len.
package clkdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   function automatic logic [31:0] eff_len(input logic [31:0] x);
      return (x == 32'd0) ? 32'd1 : x;
   endfunction

endpackage

// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider with separate high/low phase lengths,
// shadowed reconfiguration applied at period boundaries and clean stop/start.
module clkdiv_prog
   import clkdiv_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int DEF_HIGH = 50,
   parameter int DEF_LOW  = 50
) (
   input  logic             src_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_low,
   input  logic             cfg_load,
   output logic             cfg_pending,
   output logic             div_clk,
   output logic             rise_tick,
   output logic             fall_tick,
   output logic             period_done
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] act_high_q, act_low_q;
   logic [CNT_W-1:0] shd_high_q, shd_low_q;
   logic [CNT_W-1:0] eh, el;
   logic             boundary;
   logic             apply;

   assign eh = CNT_W'(eff_len(32'(act_high_q)));
   assign el = CNT_W'(eff_len(32'(act_low_q)));

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      boundary = 1'b0;
      apply    = 1'b0;
      case (state_q)
         IDLE: begin
            count_d = '0;
            apply   = cfg_pending;
            if (enable) state_d = HIGH;
         end
         HIGH: begin
            if (count_q < eh - CNT_W'(1)) begin
               count_d = count_q + CNT_W'(1);
            end else begin
               state_d = LOW;
               count_d = '0;
            end
         end
         LOW: begin
            if (count_q < el - CNT_W'(1)) begin
               count_d = count_q + CNT_W'(1);
            end else begin
               // Period boundary: the only point besides IDLE where lengths may change
               boundary = 1'b1;
               count_d  = '0;
               if (enable) begin
                  state_d = HIGH;
                  apply   = cfg_pending;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   assign rise_tick   = (state_q == HIGH) && (count_q == '0);
   assign fall_tick   = (state_q == LOW)  && (count_q == '0);
   assign period_done = boundary;

   always_ff @(posedge src_clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         div_clk     <= 1'b0;
         act_high_q  <= CNT_W'(DEF_HIGH);
         act_low_q   <= CNT_W'(DEF_LOW);
         shd_high_q  <= CNT_W'(DEF_HIGH);
         shd_low_q   <= CNT_W'(DEF_LOW);
         cfg_pending <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         div_clk <= (state_d == HIGH);
         if (apply) begin
            act_high_q <= shd_high_q;
            act_low_q  <= shd_low_q;
         end
         // A load coinciding with an apply keeps pending set for the next boundary
         if (cfg_load) begin
            shd_high_q  <= cfg_high;
            shd_low_q   <= cfg_low;
            cfg_pending <= 1'b1;
         end else if (apply) begin
            cfg_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed bench for clkdiv_prog: per-period expectations are queued as the
// stimulus is applied and checked by a monitor when each period completes.
module tb_clkdiv_prog;

   logic        src_clk;
   logic        reset;
   logic        enable;
   logic [15:0] cfg_high;
   logic [15:0] cfg_low;
   logic        cfg_load;
   logic        cfg_pending;
   logic        div_clk;
   logic        rise_tick;
   logic        fall_tick;
   logic        period_done;

   clkdiv_prog #(.CNT_W(16), .DEF_HIGH(50), .DEF_LOW(50)) dut (
      .src_clk     (src_clk),
      .reset       (reset),
      .enable      (enable),
      .cfg_high    (cfg_high),
      .cfg_low     (cfg_low),
      .cfg_load    (cfg_load),
      .cfg_pending (cfg_pending),
      .div_clk     (div_clk),
      .rise_tick   (rise_tick),
      .fall_tick   (fall_tick),
      .period_done (period_done)
   );

   initial src_clk = 1'b0;
   always #5 src_clk = ~src_clk;

   typedef struct {
      int h;
      int l;
      int nxt;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input int exp_v);
      n_assert++;
      assert (obs === 32'(exp_v)) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic push(input int h, input int l, input int nxt, input int n);
      exp_t e;
      e.h = h; e.l = l; e.nxt = nxt;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   task automatic wait_pd(input string tag);
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge src_clk);
         if (period_done) seen = 1;
      end
      if (!seen) check({tag, "_timeout"}, 32'(seen), 1);
   endtask

   task automatic wait_rise(input string tag);
      bit seen = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge src_clk);
         if (rise_tick) seen = 1;
      end
      if (!seen) check({tag, "_timeout"}, 32'(seen), 1);
   endtask

   // Period monitor: measures each completed period and pops its expectation
   int hcnt = 0, lcnt = 0, nxt_exp = 0;
   bit act_p = 0, chk_nxt = 0;
   always @(negedge src_clk) begin
      exp_t e;
      if (reset) begin
         act_p   = 0;
         chk_nxt = 0;
      end else begin
         if (chk_nxt) begin
            check("next_rise", 32'(rise_tick), nxt_exp);
            chk_nxt = 0;
         end
         if (rise_tick) begin
            hcnt  = 1;
            lcnt  = 0;
            act_p = 1;
         end else if (div_clk && act_p) begin
            hcnt++;
         end
         if (fall_tick) lcnt = 1;
         else if (!div_clk && act_p) lcnt++;
         if (period_done) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_period", 32'(sb.size()), 1);
            end else begin
               e = sb.pop_front();
               check("high_len", 32'(hcnt), e.h);
               check("low_len", 32'(lcnt), e.l);
               chk_nxt = 1;
               nxt_exp = e.nxt;
            end
            act_p = 0;
         end
      end
   end

   initial begin
      bit any_act;
      reset    = 1'b1;
      enable   = 1'b0;
      cfg_high = '0;
      cfg_low  = '0;
      cfg_load = 1'b0;
      repeat (3) @(negedge src_clk);
      check("rst_div_clk", 32'(div_clk), 0);
      check("rst_pending", 32'(cfg_pending), 0);
      check("rst_rise", 32'(rise_tick), 0);
      check("rst_fall", 32'(fall_tick), 0);
      check("rst_pd", 32'(period_done), 0);
      reset = 1'b0;
      @(negedge src_clk);
      check("idle_div_clk", 32'(div_clk), 0);

      // Defaults 50/50, first rise one cycle after enable
      push(50, 50, 1, 3);
      enable = 1'b1;
      @(negedge src_clk);
      check("first_rise", 32'(rise_tick), 1);
      check("first_div_clk", 32'(div_clk), 1);
      wait_pd("p1");
      wait_pd("p2");

      // Load 3/5 mid-HIGH; current period still 50/50
      wait_rise("p3r");
      repeat (10) @(negedge src_clk);
      cfg_high = 16'd3; cfg_low = 16'd5; cfg_load = 1'b1;
      @(negedge src_clk);
      cfg_load = 1'b0;
      check("pend_after_load", 32'(cfg_pending), 1);
      push(3, 5, 1, 3);
      wait_pd("p3");
      check("pend_at_boundary", 32'(cfg_pending), 1);
      @(negedge src_clk);
      check("pend_cleared", 32'(cfg_pending), 0);
      check("rise_35", 32'(rise_tick), 1);
      wait_pd("p4");
      wait_pd("p5");

      // Zero lengths behave as 1/1
      wait_rise("p6r");
      cfg_high = 16'd0; cfg_low = 16'd0; cfg_load = 1'b1;
      @(negedge src_clk);
      cfg_load = 1'b0;
      push(1, 1, 1, 4);
      wait_pd("p6");
      wait_pd("p7");
      wait_pd("p8");
      wait_pd("p9");

      // In a 1/1 period load 4/4, then stop one cycle after rise
      wait_rise("p10r");
      check("min_fall_off", 32'(fall_tick), 0);
      cfg_high = 16'd4; cfg_low = 16'd4; cfg_load = 1'b1;
      @(negedge src_clk);
      cfg_load = 1'b0;
      check("min_fall", 32'(fall_tick), 1);
      check("min_pd", 32'(period_done), 1);
      push(4, 4, 0, 1);
      wait_rise("p11r");
      @(negedge src_clk);
      enable = 1'b0;
      wait_pd("p11");
      any_act = 0;
      repeat (10) begin
         @(negedge src_clk);
         any_act |= div_clk | rise_tick | fall_tick | period_done;
      end
      check("idle_quiet", 32'(any_act), 0);

      // Restart, drop enable for two cycles: no gap expected
      enable = 1'b1;
      push(4, 4, 1, 2);
      push(6, 6, 1, 1);
      push(2, 2, 1, 1);
      wait_rise("q1r");
      @(negedge src_clk);
      enable = 1'b0;
      @(negedge src_clk);
      @(negedge src_clk);
      enable = 1'b1;
      wait_pd("q1");

      // Pending 6/6, then load 2/2 in the boundary cycle
      wait_rise("q2r");
      cfg_high = 16'd6; cfg_low = 16'd6; cfg_load = 1'b1;
      @(negedge src_clk);
      cfg_load = 1'b0;
      wait_pd("q2");
      check("pend_66", 32'(cfg_pending), 1);
      cfg_high = 16'd2; cfg_low = 16'd2; cfg_load = 1'b1;
      @(negedge src_clk);
      cfg_load = 1'b0;
      check("pend_stays", 32'(cfg_pending), 1);
      check("rise_66", 32'(rise_tick), 1);
      wait_pd("q3");
      @(negedge src_clk);
      check("pend_22_clear", 32'(cfg_pending), 0);
      wait_pd("q4");

      // Asynchronous reset mid-HIGH with a pending config
      @(negedge src_clk);
      check("rise_22b", 32'(rise_tick), 1);
      cfg_high = 16'd9; cfg_low = 16'd9; cfg_load = 1'b1;
      @(negedge src_clk);
      cfg_load = 1'b0;
      check("pend_99", 32'(cfg_pending), 1);
      check("div_high_pre_rst", 32'(div_clk), 1);
      #2 reset = 1'b1;
      #1;
      check("async_div_clk", 32'(div_clk), 0);
      check("async_pending", 32'(cfg_pending), 0);
      check("async_rise", 32'(rise_tick), 0);
      check("sb_drained", 32'(sb.size()), 0);
      sb.delete();
      @(negedge src_clk);
      @(negedge src_clk);
      reset = 1'b0;
      push(50, 50, 1, 1);
      @(negedge src_clk);
      check("post_rst_rise", 32'(rise_tick), 1);
      check("post_rst_pending", 32'(cfg_pending), 0);
      wait_pd("r1");
      @(negedge src_clk);
      @(negedge src_clk);
      check("sb_final", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
Runtime-programmable clock divider with an independent high-phase and low-phase count, and parametrised counter width. It generates div_clk, single-cycle edge ticks and a period-done strobe for the UART baud and oversample logic. New divide values are shadow-loaded and applied only at a period boundary. Enable start/stop is glitch-free, so div_clk never produces a runt phase.

Parameters:
CNT_W, 16, width of phase counters and cfg ports; max phase length 2^CNT_W-1 cycles
DEF_HIGH, 50, high-phase length in src_clk cycles after reset; must be 1..2^CNT_W-1
DEF_LOW, 50, low-phase length in src_clk cycles after reset; must be 1..2^CNT_W-1

Ports:
src_clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run request; level-sensitive
cfg_high  in  CNT_W  requested high-phase length; 0 is treated as 1
cfg_low  in  CNT_W  requested low-phase length; 0 is treated as 1
cfg_load  in  1  1-cycle strobe; captures cfg_high/cfg_low into shadow
cfg_pending  out  1  shadow holds values not yet applied
div_clk  out  1  divided clock, registered
rise_tick  out  1  high in the first cycle div_clk=1 of each period
fall_tick  out  1  high in the first cycle div_clk=0 after a high phase
period_done  out  1  high in the last LOW cycle of each period

Behaviour:
- Interface: one clock, src_clk; reset is asynchronous and active-high, named reset. All outputs are registered, or decoded from registered state only.
- Reset values: state=IDLE, count=0, div_clk=0, all ticks=0, cfg_pending=0. Active and shadow registers are set to DEF_HIGH/DEF_LOW.
- Effective lengths: eh = max(active_high,1), el = max(active_low,1). Period = eh+el cycles; duty = eh/(eh+el).
- FSM states: IDLE, HIGH, LOW.
- IDLE: div_clk=0. If enable=1, the next state is HIGH with count=0. If cfg_pending=1, shadow is copied to active on the same edge and pending is cleared.
- HIGH: div_clk=1. If count<eh-1, count increments. Otherwise the next state is LOW, with count=0.
- LOW: div_clk=0. If count<el-1, count increments. Otherwise this is the boundary:
  - period_done=1 this cycle.
  - If enable=1: next state is HIGH with count=0, and a pending shadow is applied on this edge.
  - If enable=0: next state is IDLE.
- Stop: deasserting enable mid-period never truncates a phase. The current period completes, then the FSM goes to IDLE. Re-asserting enable before the boundary gives seamless continuation with no gap.
- Reconfiguration:
  - cfg_load sets shadow and cfg_pending=1 on the next edge.
  - cfg_load in the same cycle as a boundary does not affect that boundary. The old shadow (if pending) is applied, the new values are latched, and cfg_pending stays 1 for the following boundary.
  - Multiple cfg_loads before a boundary: last one wins.
- Ticks: rise_tick is asserted in the first HIGH cycle, fall_tick in the first LOW cycle. Each is high for exactly 1 cycle per period.
- Minimum case eh=el=1: div_clk=src_clk/2. rise_tick and fall_tick alternate every cycle. period_done coincides with fall_tick.
- Arithmetic: unsigned CNT_W-bit compares. The counter never exceeds max(eh,el)-1 and never wraps.
- Reset mid-operation: immediate return to reset values, with any pending shadow discarded.

Decomposition:
- Package clkdiv_pkg: state_t enum (IDLE, HIGH, LOW) and a function eff_len(x) that returns the value with 0 mapped to 1.
- Single module. Shadow/pending logic stays inline; no sub-module is warranted.

Test Plan:
1. Reset with defaults, enable=1 held -> first rise_tick 1 cycle after enable. div_clk high 50 / low 50 repeating. period_done every 100 cycles.
2. cfg_high=3, cfg_low=5, cfg_load mid-HIGH of a 50/50 period -> current period finishes 50/50 with cfg_pending=1. Next period is 3 high / 5 low; cfg_pending clears at that boundary.
3. cfg_high=0, cfg_low=0 loaded -> behaves as 1/1. div_clk toggles every cycle; rise_tick and fall_tick alternate.
4. Period 4/4 running, enable dropped 1 cycle after rise_tick -> 3 more high cycles and 4 low, period_done once, then IDLE with div_clk=0 and no further ticks. Same case with enable re-raised 2 cycles later -> no gap.
5. cfg_load(2,2) in the period_done cycle while the shadow already pends (6,6) -> next period is 6/6, cfg_pending stays 1, and the following period is 2/2.
6. Assert reset mid-HIGH with pending config -> div_clk=0 and cfg_pending=0 asynchronously. After release with enable=1, 50/50 resumes.
